// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative 32-bit multiply/divide unit for the EX stage.
// Runs MULT/MULTU (shift-add, LSB first) and DIV/DIVU (restoring, MSB first)
// over 32 iterations. The result lands in HI/LO one cycle later.
//
// Ports:
//   clk_i          rising-edge clock
//   rst_i          asynchronous active-high reset
//   start_i        launch an operation (honoured only while idle)
//   op_i           00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   a_i, b_i       multiplicand/dividend, multiplier/divisor
//   hi_write_i     MTHI strobe (idle only)
//   lo_write_i     MTLO strobe (idle only)
//   write_data_i   data for MTHI/MTLO
//   busy_o         operation in progress
//   done_o         one-cycle pulse when HI/LO take a new result
//   hi_o, lo_o     HI/LO registers
module mult_div_unit (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic [1:0]  op_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic        hi_write_i,
    input  logic        lo_write_i,
    input  logic [31:0] write_data_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o
);

    typedef enum logic [1:0] {StIdle, StRun, StFinish} state_e;

    state_e      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [63:0] acc_q, acc_d;
    logic [31:0] a_q, a_d;        // multiplicand / dividend magnitude
    logic [31:0] b_q, b_d;        // multiplier / divisor magnitude
    logic        div_q, div_d;
    logic        neg_q, neg_d;    // negate product or quotient
    logic        rneg_q, rneg_d;  // negate remainder (dividend sign)
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic        done_q, done_d;

    // Operand preparation at Start
    logic        is_signed, a_neg, b_neg;
    logic [31:0] a_mag, b_mag;

    assign is_signed = ~op_i[0];
    assign a_neg     = is_signed & a_i[31];
    assign b_neg     = is_signed & b_i[31];
    assign a_mag     = a_neg ? (32'd0 - a_i) : a_i;
    assign b_mag     = b_neg ? (32'd0 - b_i) : b_i;

    // One multiply step: add multiplicand into the upper half, shift right.
    logic [32:0] mul_sum;
    logic [63:0] mul_next;

    assign mul_sum  = {1'b0, acc_q[63:32]} + {1'b0, (b_q[0] ? a_q : 32'd0)};
    assign mul_next = {mul_sum, acc_q[31:1]};

    // One restoring divide step: remainder in acc[63:32], quotient in acc[31:0].
    // The shifted remainder needs 33 bits; after the step it always fits 32.
    logic [32:0] div_shift;
    logic [33:0] div_diff;
    logic        div_ge;
    logic [31:0] div_rem;
    logic [63:0] div_next;

    assign div_shift = {acc_q[63:32], a_q[31]};
    assign div_diff  = {1'b0, div_shift} - {2'b00, b_q};
    assign div_ge    = ~div_diff[33];
    assign div_rem   = div_ge ? div_diff[31:0] : div_shift[31:0];
    assign div_next  = {div_rem, acc_q[30:0], div_ge};

    // Sign fix-up for the FINISH write
    logic [63:0] prod_fix;
    logic [31:0] res_hi, res_lo;

    assign prod_fix = neg_q ? (64'd0 - acc_q) : acc_q;

    always_comb begin
        if (div_q) begin
            res_lo = neg_q ? (32'd0 - acc_q[31:0]) : acc_q[31:0];
            res_hi = rneg_q ? (32'd0 - acc_q[63:32]) : acc_q[63:32];
        end else begin
            res_lo = prod_fix[31:0];
            res_hi = prod_fix[63:32];
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        a_d     = a_q;
        b_d     = b_q;
        div_d   = div_q;
        neg_d   = neg_q;
        rneg_d  = rneg_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (hi_write_i) hi_d = write_data_i;
                if (lo_write_i) lo_d = write_data_i;
                if (start_i) begin
                    state_d = StRun;
                    cnt_d   = 5'd0;
                    acc_d   = 64'd0;
                    a_d     = a_mag;
                    b_d     = b_mag;
                    div_d   = op_i[1];
                    // A zero divisor keeps the quotient at all-ones and lets
                    // the remainder come back as the original dividend.
                    neg_d   = (a_neg ^ b_neg) & (|b_i);
                    rneg_d  = a_neg;
                end
            end
            StRun: begin
                if (div_q) begin
                    acc_d = div_next;
                    a_d   = {a_q[30:0], 1'b0};
                end else begin
                    acc_d = mul_next;
                    b_d   = {1'b0, b_q[31:1]};
                end
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd31) state_d = StFinish;
            end
            StFinish: begin
                hi_d    = res_hi;
                lo_d    = res_lo;
                done_d  = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            cnt_q   <= 5'd0;
            acc_q   <= 64'd0;
            a_q     <= 32'd0;
            b_q     <= 32'd0;
            div_q   <= 1'b0;
            neg_q   <= 1'b0;
            rneg_q  <= 1'b0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            a_q     <= a_d;
            b_q     <= b_d;
            div_q   <= div_d;
            neg_q   <= neg_d;
            rneg_q  <= rneg_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
        end
    end

    assign busy_o = (state_q != StIdle);
    assign done_o = done_q;
    assign hi_o   = hi_q;
    assign lo_o   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit with a result scoreboard.
module tb_mult_div_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a, b;
    logic        hi_write, lo_write;
    logic [31:0] wdata;
    logic        busy, done;
    logic [31:0] hi, lo;

    int checks = 0;
    int errors = 0;
    logic [63:0] sb_q[$];

    always #5 clk = ~clk;

    mult_div_unit dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .start_i      (start),
        .op_i         (op),
        .a_i          (a),
        .b_i          (b),
        .hi_write_i   (hi_write),
        .lo_write_i   (lo_write),
        .write_data_i (wdata),
        .busy_o       (busy),
        .done_o       (done),
        .hi_o         (hi),
        .lo_o         (lo)
    );

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", name, got, exp);
        end
    endtask

    // Drive one Start pulse and record the expected {HI, LO}.
    task automatic start_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                            input logic [63:0] exp);
        @(negedge clk);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        sb_q.push_back(exp);
        @(negedge clk);
        start = 1'b0;
    endtask

    // Wait (bounded) for Done, then check timing and pop/compare the result.
    task automatic wait_result(input string name, input int exp_lat, input int exp_busy);
        int cyc = 0;
        int nbusy = 0;
        logic [63:0] e;
        while (done !== 1'b1 && cyc < 100) begin
            if (busy === 1'b1) nbusy++;
            @(negedge clk);
            cyc++;
        end
        check({name, "_latency"}, 64'(cyc), 64'(exp_lat));
        check({name, "_busy_cycles"}, 64'(nbusy), 64'(exp_busy));
        check({name, "_busy_fall"}, 64'(busy), 64'd0);
        check({name, "_sb_nonempty"}, 64'(sb_q.size() > 0), 64'd1);
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check({name, "_result"}, {hi, lo}, e);
        end
        @(negedge clk);
        check({name, "_done_fall"}, 64'(done), 64'd0);
    endtask

    initial begin
        logic saw_done;
        rst      = 1'b1;
        start    = 1'b0;
        op       = 2'b00;
        a        = 32'd0;
        b        = 32'd0;
        hi_write = 1'b0;
        lo_write = 1'b0;
        wdata    = 32'd0;

        #12;
        check("reset_hilo", {hi, lo}, 64'd0);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        start_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);
        wait_result("multu_max", 33, 33);

        start_op(2'b00, 32'hFFFF_FFFD, 32'd7, 64'hFFFF_FFFF_FFFF_FFEB);
        wait_result("mult_neg", 33, 33);

        start_op(2'b10, 32'hFFFF_FFF9, 32'd2, 64'hFFFF_FFFF_FFFF_FFFD);
        wait_result("div_neg", 33, 33);

        start_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000);
        wait_result("div_ovf", 33, 33);

        start_op(2'b10, 32'hFFFF_FF9C, 32'd0, 64'hFFFF_FF9C_FFFF_FFFF);
        wait_result("div_by0", 33, 33);

        start_op(2'b11, 32'd100, 32'd0, 64'h0000_0064_FFFF_FFFF);
        wait_result("divu_by0", 33, 33);

        // MTHI while idle
        @(negedge clk);
        hi_write = 1'b1;
        wdata    = 32'h0000_1234;
        @(negedge clk);
        hi_write = 1'b0;
        check("mthi", {hi, lo}, 64'h0000_1234_FFFF_FFFF);

        // Start/MTLO during busy are ignored
        start_op(2'b11, 32'd10, 32'd3, 64'h0000_0001_0000_0003);
        repeat (4) @(negedge clk);
        start    = 1'b1;
        op       = 2'b01;
        a        = 32'd2;
        b        = 32'd2;
        lo_write = 1'b1;
        wdata    = 32'hDEAD_BEEF;
        @(negedge clk);
        start    = 1'b0;
        lo_write = 1'b0;
        check("busy_ignores_mtlo", {hi, lo}, 64'h0000_1234_FFFF_FFFF);
        wait_result("divu_busy_start", 28, 28);
        check("sb_drained", 64'(sb_q.size()), 64'd0);

        // Reset mid-operation at iteration 10
        @(negedge clk);
        start = 1'b1;
        op    = 2'b00;
        a     = 32'd5;
        b     = 32'd6;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check("abort_hilo", {hi, lo}, 64'd0);
        check("abort_busy", 64'(busy), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        saw_done = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (done === 1'b1) saw_done = 1'b1;
        end
        check("abort_no_done", 64'(saw_done), 64'd0);
        check("abort_hilo_after", {hi, lo}, 64'd0);

        start_op(2'b00, 32'd5, 32'hFFFF_FFFA, 64'hFFFF_FFFF_FFFF_FFE2);
        wait_result("mult_after_reset", 33, 33);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mult_div_unit.md
# mult_div_unit

Iterative 32-bit multiply/divide unit for the EX stage, next to the 32-bit ALU. It takes the same A/B operands from ID/EX and runs MIPS MULT, MULTU, DIV and DIVU over 32 clock cycles. Results land in internal HI/LO registers, which MFHI/MFLO select onto the ALU result path. While a job runs, Busy stalls the hazard unit.

## Interface
- No parameters. Data width is fixed at 32; HI/LO form a 64-bit result pair.
- Clk  input  1  rising-edge clock; the only clock.
- Reset  input  1  asynchronous, active-high reset.
- Start  input  1  launches an operation. Honoured only when Busy=0.
- Op  input  2  operation select, sampled with Start:
  - 00 MULT (signed)
  - 01 MULTU
  - 10 DIV (signed)
  - 11 DIVU
- A  input  32  multiplicand / dividend, sampled with Start.
- B  input  32  multiplier / divisor, sampled with Start.
- HiWrite  input  1  MTHI: HI <= WriteData.
- LoWrite  input  1  MTLO: LO <= WriteData.
- WriteData  input  32  data for MTHI/MTLO.
- Busy  output  1  high while an operation is in progress.
- Done  output  1  one-cycle pulse when HI/LO take a new result.
- HI  output  32  HI register: product[63:32] or remainder.
- LO  output  32  LO register: product[31:0] or quotient.

## Operation
- States:
  - IDLE: Busy=0.
  - RUN: Busy=1, 5-bit iteration counter.
  - FINISH: one cycle of sign fix-up and HI/LO write.
- Transitions:
  - IDLE → RUN on Start=1. The edge latches Op, magnitudes of A/B (signed ops only), sign flags, and clears the accumulator and counter.
  - RUN → FINISH after iteration 31.
  - FINISH → IDLE on the next edge.
- Multiply: shift-add, one multiplier bit per cycle, LSB first, into a 64-bit accumulator. For MULT, negate the 64-bit result (two's complement) when the sign of A differs from the sign of B.
- Divide: restoring division, one quotient bit per cycle, MSB first.
  - For DIV: the quotient is negated if the operand signs differ; the remainder takes the sign of the dividend.
  - -2^31 / -1 yields LO=0x80000000, HI=0x00000000. No trap.
- Divide by zero (DIV or DIVU): still runs the full 32 cycles. Result is LO=0xFFFFFFFF, HI=A as sampled (the original signed value for DIV).
- MTHI/MTLO:
  - Applied on the clock edge only when Busy=0; ignored while Busy=1.
  - HiWrite/LoWrite in the same cycle as an accepted Start: the write still applies, and the later result overwrites it.
- Start while Busy=1 is ignored. The in-flight operation and its operands are not disturbed.
- HI/LO are never partially updated. They change only at the FINISH edge, on reset, or through MTHI/MTLO.

## Timing
- Reset (asynchronous, any time including mid-operation): state=IDLE, Busy=0, Done=0, HI=0, LO=0, counter=0, accumulator=0. An aborted operation produces no result.
- Edge 0 (Start accepted): Busy rises after this edge.
- Edges 1..32: iterations 0..31.
- Edge 33 (FINISH): HI/LO are written, Busy falls, Done rises.
- Edge 34: Done falls.
- Latency: the result is visible on HI/LO 33 cycles after the Start edge.
- A new Start is accepted in the same cycle Done=1 (back-to-back), giving a throughput of one operation per 34 cycles.
- Busy is registered and has no combinational path from Start. HI and LO are direct register outputs.

## Test plan
- MULTU with A=0xFFFFFFFF, B=0xFFFFFFFF → after 33 cycles HI=0xFFFFFFFE, LO=0x00000001; Done high for exactly one cycle; Busy high for 33 cycles.
- MULT with A=0xFFFFFFFD (-3), B=7 → HI=0xFFFFFFFF, LO=0xFFFFFFEB (-21).
- DIV with A=0xFFFFFFF9 (-7), B=2 → LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1).
- DIV with A=0x80000000, B=0xFFFFFFFF → LO=0x80000000, HI=0x00000000.
- DIVU with A=100, B=0 → LO=0xFFFFFFFF, HI=0x00000064.
- Sequencing, three sub-checks:
  - MTHI 0x1234 while idle → HI=0x1234 next cycle.
  - Start DIVU 10/3 then, 5 cycles later, Start MULTU 2*2 plus LoWrite → both ignored; the result is HI=1, LO=3.
  - Assert Reset at iteration 10 of a further op → HI=LO=0, Busy=0, no Done pulse.
